// File: rtl/mux_scan_n.sv
// N-channel registered display multiplexer with MANUAL select and AUTO scan modes.
// Optional blanking after each channel change is enabled by defining MUX_SCAN_BLANK_EN.
module mux_scan_n #(
  parameter int WIDTH = 7,
  parameter int CHANNELS = 3,
  parameter int DWELL = 4,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
`ifdef MUX_SCAN_BLANK_EN
  parameter int BLANK_CYCLES = 1,
`endif
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] d_in,
  input  logic [SELW-1:0]           sel,
  input  logic                      auto_en,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_ch,
  output logic [CHANNELS-1:0]       digit_en,
  output logic                      strobe
);

  localparam int CNTW = $clog2(DWELL) + 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] CH_LAST = SELW'(CHANNELS - 1);

  typedef enum logic {MANUAL, AUTO} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nxt;
  logic [SELW-1:0] ch_nxt;
  logic            strobe_nxt;
  logic            blank_nxt;

  // Out-of-range indices fall through to DEFAULT_VAL / no enable.
  function automatic logic [WIDTH-1:0] pick(input logic [SELW-1:0] idx,
                                            input logic [CHANNELS*WIDTH-1:0] bus);
    pick = DEFAULT_VAL;
    for (int k = 0; k < CHANNELS; k++)
      if (idx == SELW'(k)) pick = bus[k*WIDTH +: WIDTH];
  endfunction

  function automatic logic [CHANNELS-1:0] onehot(input logic [SELW-1:0] idx);
    onehot = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (idx == SELW'(k)) onehot[k] = 1'b1;
  endfunction

  // The AUTO scan index lives in out_ch itself; MANUAL simply overwrites it with sel.
  always_comb begin
    ch_nxt     = out_ch;
    cnt_nxt    = cnt;
    strobe_nxt = 1'b0;
    if (!auto_en) begin
      ch_nxt  = sel;
      cnt_nxt = '0;
    end else if (state == MANUAL) begin
      ch_nxt     = '0;
      cnt_nxt    = '0;
      strobe_nxt = 1'b1;
    end else if (!hold) begin
      if (cnt == CNT_LAST) begin
        ch_nxt     = (out_ch == CH_LAST) ? '0 : out_ch + SELW'(1);
        cnt_nxt    = '0;
        strobe_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + CNTW'(1);
      end
    end
`ifdef MUX_SCAN_BLANK_EN
    blank_nxt = auto_en && (cnt_nxt < CNTW'(BLANK_CYCLES));
`else
    blank_nxt = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= MANUAL;
      cnt      <= '0;
      out_data <= DEFAULT_VAL;
      out_ch   <= '0;
      digit_en <= '0;
      strobe   <= 1'b0;
    end else begin
      state    <= auto_en ? AUTO : MANUAL;
      cnt      <= cnt_nxt;
      out_ch   <= ch_nxt;
      strobe   <= strobe_nxt;
      out_data <= blank_nxt ? DEFAULT_VAL : pick(ch_nxt, d_in);
      digit_en <= blank_nxt ? '0 : onehot(ch_nxt);
    end
  end

endmodule
